sys_ctrl_fsm: RTL
=================

Name: sys_ctrl_fsm

Overview:
- Command-decoding controller between the UART RX deserializer and the register file / ALU.
- Parses byte-framed commands from RX and issues single-cycle write/read strobes to the register file.
- Launches ALU operations and queues response bytes toward the UART TX path.
- Directly upstream of the register file: it produces every write/read request and consumes the read data and read-valid it returns.

Parameters:
- DATA_WD, 8, width of RX/TX bytes and register data.
- ADDR_WD, 4, register file address width.
- ALU_OUT_WD, 16, ALU result width (2 bytes).
- FUN_WD, 4, ALU function code width.
- TIMEOUT_CYC, 1024, inter-byte timeout in CLK cycles (used only with the optional feature).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- RX_P_DATA  in  DATA_WD  received byte.
- RX_D_VLD  in  1  one-cycle pulse; RX_P_DATA valid.
- RD_DATA  in  DATA_WD  register file read data.
- RD_DATA_VLD  in  1  register file read-data valid.
- ALU_OUT  in  ALU_OUT_WD  ALU result.
- ALU_OUT_VLD  in  1  ALU result valid.
- TX_FULL  in  1  TX queue cannot accept a byte.
- WrEn  out  1  register write strobe.
- RdEn  out  1  register read strobe.
- ADDR  out  ADDR_WD  register address.
- WR_DATA  out  DATA_WD  register write data.
- ALU_EN  out  1  ALU enable.
- ALU_FUN  out  FUN_WD  ALU function select.
- CLK_GATE_EN  out  1  ALU clock-gate enable.
- TX_P_DATA  out  DATA_WD  byte to transmit.
- TX_D_VLD  out  1  one-cycle push of TX_P_DATA.

Behaviour:
- Reset: all outputs 0; state IDLE; internal address/operand/result registers 0.
- Command opcodes (first byte):
  - 0xAA: write; frame = addr, data.
  - 0xBB: read; frame = addr.
  - 0xCC: ALU with operands; frame = A, B, fun.
  - 0xDD: ALU without operands; frame = fun.
  - Any other first byte is dropped; stay in IDLE.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI. Byte-consuming states advance only on RX_D_VLD.
- Write (0xAA):
  - WR_ADDR latches RX_P_DATA[ADDR_WD-1:0].
  - In WR_DATA, on RX_D_VLD: WrEn=1 with ADDR and WR_DATA=RX_P_DATA for exactly one cycle, RdEn=0; then IDLE. No TX response.
- Read (0xBB):
  - RD_ADDR, on RX_D_VLD: RdEn=1 for one cycle with ADDR=byte; go to RD_WAIT.
  - RD_WAIT waits for RD_DATA_VLD (arrives the next cycle), latches RD_DATA, goes to TX_LO.
- ALU with operands (0xCC):
  - OP_A byte: WrEn to address 0. OP_B byte: WrEn to address 1.
  - ALU_FUN byte: CLK_GATE_EN=1; ALU_EN=1 for one cycle with ALU_FUN=byte[FUN_WD-1:0]; go to ALU_WAIT.
- ALU without operands (0xDD): enters ALU_FUN directly.
- ALU_WAIT:
  - CLK_GATE_EN held 1 until ALU_OUT_VLD.
  - On ALU_OUT_VLD: latch ALU_OUT, drop CLK_GATE_EN the following cycle, send low byte (TX_LO) then high byte (TX_HI).
- TX handshake:
  - In TX_LO/TX_HI, TX_D_VLD=1 for one cycle only when TX_FULL=0. TX_P_DATA stable during that cycle.
  - While TX_FULL=1, hold state with TX_D_VLD=0.
  - Read responses send one byte from TX_LO, then IDLE. ALU responses go TX_LO -> TX_HI -> IDLE.
- WrEn and RdEn are never asserted together. Each strobe is exactly one cycle.
- An RX_D_VLD arriving in RD_WAIT, ALU_WAIT, TX_LO or TX_HI is dropped.
- Asynchronous RST mid-frame: immediately returns to IDLE and clears all strobes; a partial command has no effect.

Optional Feature:
- Macro SYS_CTRL_TIMEOUT_EN.
- When defined:
  - A counter resets on every accepted RX_D_VLD.
  - If TIMEOUT_CYC cycles elapse in WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B or ALU_FUN without a byte, return to IDLE with no strobe issued.
  - Already-issued operand writes are not undone.
- When undefined: these states wait indefinitely; the counter logic is absent.

Test Plan:
- Write then read:
  - Frames AA,05,3C then BB,05: WrEn pulse with ADDR=5, WR_DATA=0x3C.
  - RdEn pulse with ADDR=5; RD_DATA=0x3C returned; one TX_D_VLD with TX_P_DATA=0x3C.
- ALU with operands:
  - Frames CC,0A,03,00: WrEn ADDR=0 data 0x0A, then WrEn ADDR=1 data 0x03.
  - ALU_EN with ALU_FUN=0; ALU_OUT=0x000D returned; TX bytes 0x0D then 0x00.
- ALU without operands plus back-pressure:
  - Frames DD,02 with TX_FULL=1 for 20 cycles after ALU_OUT_VLD (ALU_OUT=0x1234).
  - No TX_D_VLD while TX_FULL=1; then TX bytes 0x34, 0x12.
- Unknown opcode: byte 0x55 then AA,01,FF: 0x55 ignored; single WrEn ADDR=1 data 0xFF.
- Reset mid-frame: AA,07, assert RST, release, then AA,02,11: no write to address 7; one write to ADDR=2 data 0x11.
- Timeout (SYS_CTRL_TIMEOUT_EN defined, TIMEOUT_CYC=16):
  - BB followed by 20 idle cycles, then 05: no RdEn issued.
  - The 05 is treated as an opcode and ignored; FSM is in IDLE.

Source files
------------

// File: rtl/sys_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// sys_ctrl_fsm
//
// Command-decoding controller between the UART RX deserializer and the
// register file / ALU. Byte-framed commands arrive on RX_P_DATA/RX_D_VLD and
// are turned into single-cycle register write/read strobes and ALU launches.
// Read data and ALU results are returned as bytes on the TX push interface.
//
// Command frames (first byte is the opcode):
//   0xAA addr data   register write
//   0xBB addr        register read, one response byte
//   0xCC A B fun     write operands to regs 0/1, run ALU, two response bytes
//   0xDD fun         run ALU on current regs 0/1, two response bytes
//   anything else    dropped while idle
//
// Ports:
//   CLK, RST        clock (rising edge), asynchronous active-high reset
//   RX_P_DATA       received byte, qualified by RX_D_VLD (one-cycle pulse)
//   RD_DATA         register file read data, qualified by RD_DATA_VLD
//   ALU_OUT         ALU result, qualified by ALU_OUT_VLD
//   TX_FULL         TX queue cannot accept a byte
//   WrEn, RdEn      one-cycle register write / read strobes
//   ADDR, WR_DATA   register address and write data
//   ALU_EN, ALU_FUN one-cycle ALU launch and function select
//   CLK_GATE_EN     ALU clock-gate enable, held from launch until result
//   TX_P_DATA       byte to transmit, pushed by one-cycle TX_D_VLD
//
// Optional build macro:
//   SYS_CTRL_TIMEOUT_EN  when defined, a frame that stalls for TIMEOUT_CYC
//                        cycles between bytes is abandoned and the FSM
//                        returns to IDLE without issuing the pending strobe.
// ----------------------------------------------------------------------------
module sys_ctrl_fsm #(
    parameter int DATA_WD     = 8,
    parameter int ADDR_WD     = 4,
    parameter int ALU_OUT_WD  = 16,
    parameter int FUN_WD      = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WD-1:0]    RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic [DATA_WD-1:0]    RD_DATA,
    input  logic                  RD_DATA_VLD,
    input  logic [ALU_OUT_WD-1:0] ALU_OUT,
    input  logic                  ALU_OUT_VLD,
    input  logic                  TX_FULL,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WD-1:0]    ADDR,
    output logic [DATA_WD-1:0]    WR_DATA,
    output logic                  ALU_EN,
    output logic [FUN_WD-1:0]     ALU_FUN,
    output logic                  CLK_GATE_EN,
    output logic [DATA_WD-1:0]    TX_P_DATA,
    output logic                  TX_D_VLD
);

    localparam logic [DATA_WD-1:0] OPC_WRITE   = DATA_WD'(8'hAA);
    localparam logic [DATA_WD-1:0] OPC_READ    = DATA_WD'(8'hBB);
    localparam logic [DATA_WD-1:0] OPC_ALU_OP  = DATA_WD'(8'hCC);
    localparam logic [DATA_WD-1:0] OPC_ALU_NOP = DATA_WD'(8'hDD);

    // The counter below needs at least one cycle of headroom to be meaningful.
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("sys_ctrl_fsm: TIMEOUT_CYC must be at least 2");
    end

    // State names carry an S_ prefix so they do not collide with the
    // WR_DATA / ALU_FUN port names.
    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_WAIT,
        S_OP_A,
        S_OP_B,
        S_ALU_FUN,
        S_ALU_WAIT,
        S_TX_LO,
        S_TX_HI
    } state_t;

    state_t                  state;
    logic [ADDR_WD-1:0]      addr_reg;
    logic [ALU_OUT_WD-1:0]   result_reg;
    logic                    is_read;
    logic                    timeout_hit;

`ifdef SYS_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    logic [CNT_W-1:0] idle_cnt;
    logic             byte_state;

    // Only states that are waiting for a frame byte are subject to timeout.
    assign byte_state = (state == S_WR_ADDR) || (state == S_WR_DATA) ||
                        (state == S_RD_ADDR) || (state == S_OP_A)    ||
                        (state == S_OP_B)    || (state == S_ALU_FUN);

    // Fires on the last of TIMEOUT_CYC consecutive byte-less cycles.
    assign timeout_hit = byte_state && !RX_D_VLD &&
                         (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idle_cnt <= '0;
        end else if (!byte_state || RX_D_VLD || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Single registered FSM. Strobes default low every cycle so each one is
    // exactly one cycle wide; ADDR/WR_DATA/ALU_FUN/TX_P_DATA hold their last
    // value between strobes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            addr_reg    <= '0;
            result_reg  <= '0;
            is_read     <= 1'b0;
            WrEn        <= 1'b0;
            RdEn        <= 1'b0;
            ADDR        <= '0;
            WR_DATA     <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
        end else begin
            WrEn     <= 1'b0;
            RdEn     <= 1'b0;
            ALU_EN   <= 1'b0;
            TX_D_VLD <= 1'b0;

            if (timeout_hit) begin
                // Abandon the partial frame; operand writes already issued stay.
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (RX_D_VLD) begin
                            if (RX_P_DATA == OPC_WRITE) begin
                                state <= S_WR_ADDR;
                            end else if (RX_P_DATA == OPC_READ) begin
                                state <= S_RD_ADDR;
                            end else if (RX_P_DATA == OPC_ALU_OP) begin
                                state <= S_OP_A;
                            end else if (RX_P_DATA == OPC_ALU_NOP) begin
                                state <= S_ALU_FUN;
                            end
                        end
                    end

                    S_WR_ADDR: begin
                        if (RX_D_VLD) begin
                            addr_reg <= RX_P_DATA[ADDR_WD-1:0];
                            state    <= S_WR_DATA;
                        end
                    end

                    S_WR_DATA: begin
                        if (RX_D_VLD) begin
                            WrEn    <= 1'b1;
                            ADDR    <= addr_reg;
                            WR_DATA <= RX_P_DATA;
                            state   <= S_IDLE;
                        end
                    end

                    S_RD_ADDR: begin
                        if (RX_D_VLD) begin
                            RdEn  <= 1'b1;
                            ADDR  <= RX_P_DATA[ADDR_WD-1:0];
                            state <= S_RD_WAIT;
                        end
                    end

                    S_RD_WAIT: begin
                        if (RD_DATA_VLD) begin
                            result_reg <= ALU_OUT_WD'(RD_DATA);
                            is_read    <= 1'b1;
                            state      <= S_TX_LO;
                        end
                    end

                    S_OP_A: begin
                        if (RX_D_VLD) begin
                            WrEn    <= 1'b1;
                            ADDR    <= '0;
                            WR_DATA <= RX_P_DATA;
                            state   <= S_OP_B;
                        end
                    end

                    S_OP_B: begin
                        if (RX_D_VLD) begin
                            WrEn    <= 1'b1;
                            ADDR    <= ADDR_WD'(1);
                            WR_DATA <= RX_P_DATA;
                            state   <= S_ALU_FUN;
                        end
                    end

                    S_ALU_FUN: begin
                        if (RX_D_VLD) begin
                            CLK_GATE_EN <= 1'b1;
                            ALU_EN      <= 1'b1;
                            ALU_FUN     <= RX_P_DATA[FUN_WD-1:0];
                            state       <= S_ALU_WAIT;
                        end
                    end

                    S_ALU_WAIT: begin
                        // The gate stays open until the result has been captured.
                        if (ALU_OUT_VLD) begin
                            result_reg  <= ALU_OUT;
                            is_read     <= 1'b0;
                            CLK_GATE_EN <= 1'b0;
                            state       <= S_TX_LO;
                        end
                    end

                    S_TX_LO: begin
                        if (!TX_FULL) begin
                            TX_D_VLD  <= 1'b1;
                            TX_P_DATA <= result_reg[DATA_WD-1:0];
                            state     <= is_read ? S_IDLE : S_TX_HI;
                        end
                    end

                    S_TX_HI: begin
                        if (!TX_FULL) begin
                            TX_D_VLD  <= 1'b1;
                            TX_P_DATA <= result_reg[ALU_OUT_WD-1 -: DATA_WD];
                            state     <= S_IDLE;
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
